// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: load-use / ID-branch stalls, cache-miss freeze, taken-redirect flush, halt drain.
// Zero-latency combinational controls; optional perf counters behind HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ID_valid,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_use_rs1,
  input  logic             ID_use_rs2,
  input  logic             ID_is_branch,
  input  logic             ID_taken,
  input  logic             ID_halt,
  input  logic             IDEX_MemRead,
  input  logic             IDEX_RegWrite,
  input  logic [4:0]       IDEX_rd,
  input  logic             EXMEM_MemRead,
  input  logic [4:0]       EXMEM_rd,
  input  logic             ICache_stall,
  input  logic             DCache_stall,
  output logic             PC_write,
  output logic             IFID_write,
  output logic             IFID_flush,
  output logic             IDEX_flush,
  output logic             pipe_freeze,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

  state_t     state_q, state_d;
  logic [3:0] drain_q, drain_d;
  logic       halted_q, halted_d;
  logic       match_ex, match_mem, freeze, hazard;

  assign match_ex  = (IDEX_rd != 5'd0) &&
                     ((IDEX_rd == ID_rs1 && ID_use_rs1) || (IDEX_rd == ID_rs2 && ID_use_rs2));
  assign match_mem = (EXMEM_rd != 5'd0) &&
                     ((EXMEM_rd == ID_rs1 && ID_use_rs1) || (EXMEM_rd == ID_rs2 && ID_use_rs2));
  assign freeze    = ICache_stall | DCache_stall;
  assign hazard    = ID_valid && ((IDEX_MemRead && match_ex) ||
                                  (ID_is_branch && IDEX_RegWrite && match_ex) ||
                                  (ID_is_branch && EXMEM_MemRead && match_mem));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      drain_q  <= 4'd0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    PC_write    = 1'b1;
    IFID_write  = 1'b1;
    IFID_flush  = 1'b0;
    IDEX_flush  = 1'b0;
    pipe_freeze = 1'b0;
    state_d     = state_q;
    drain_d     = drain_q;
    halted_d    = halted_q;
    if (freeze) begin
      // A cache miss holds everything, including the drain countdown.
      pipe_freeze = 1'b1;
      PC_write    = 1'b0;
      IFID_write  = 1'b0;
    end else begin
      case (state_q)
        HALTED: begin
          PC_write   = 1'b0;
          IFID_write = 1'b0;
          IDEX_flush = 1'b1;
        end
        DRAIN: begin
          PC_write   = 1'b0;
          IFID_write = 1'b0;
          IDEX_flush = 1'b1;
          drain_d    = drain_q - 4'd1;
          if (drain_q <= 4'd1) begin
            state_d  = HALTED;
            halted_d = 1'b1;
          end
        end
        RUN: begin
          if (hazard) begin
            PC_write   = 1'b0;
            IFID_write = 1'b0;
            IDEX_flush = 1'b1;
          end else if (ID_valid && ID_halt) begin
            PC_write   = 1'b0;
            IFID_flush = 1'b1;
            state_d    = DRAIN;
            drain_d    = DRAIN_INIT;
          end else if (ID_valid && ID_taken) begin
            IFID_flush = 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
    if (!rst_n) begin
      PC_write    = 1'b0;
      IFID_write  = 1'b0;
      IFID_flush  = 1'b1;
      IDEX_flush  = 1'b1;
      pipe_freeze = 1'b0;
    end
  end

  assign halted = halted_q;

`ifdef HAZARD_PERF_CNT_EN
  logic             stall_inc, flush_inc;
  logic [CNT_W-1:0] stall_q, flush_q;

  assign stall_inc = (state_q == RUN) && (freeze || hazard);
  assign flush_inc = (state_q == RUN) && !freeze && !hazard && ID_valid && !ID_halt && ID_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_inc && stall_q != '1) stall_q <= stall_q + 1'b1;
      if (flush_inc && flush_q != '1) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a rule-level model.
module tb_hazard_ctrl;
  localparam int DRAIN_CYCLES = 3;
  localparam int CNT_W        = 32;

  logic             clk = 1'b1;
  logic             rst_n;
  logic             ID_valid, ID_use_rs1, ID_use_rs2, ID_is_branch, ID_taken, ID_halt;
  logic [4:0]       ID_rs1, ID_rs2, IDEX_rd, EXMEM_rd;
  logic             IDEX_MemRead, IDEX_RegWrite, EXMEM_MemRead, ICache_stall, DCache_stall;
  logic             PC_write, IFID_write, IFID_flush, IDEX_flush, pipe_freeze, halted;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  hazard_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ID_valid(ID_valid), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2), .ID_is_branch(ID_is_branch),
    .ID_taken(ID_taken), .ID_halt(ID_halt), .IDEX_MemRead(IDEX_MemRead),
    .IDEX_RegWrite(IDEX_RegWrite), .IDEX_rd(IDEX_rd), .EXMEM_MemRead(EXMEM_MemRead),
    .EXMEM_rd(EXMEM_rd), .ICache_stall(ICache_stall), .DCache_stall(DCache_stall),
    .PC_write(PC_write), .IFID_write(IFID_write), .IFID_flush(IFID_flush),
    .IDEX_flush(IDEX_flush), .pipe_freeze(pipe_freeze), .halted(halted),
    .stall_cycles(stall_cycles), .flush_count(flush_count));

  always #5 clk = ~clk;

  // Model state: remaining non-frozen drain cycles, sticky halted, unbounded counts (saturated on use).
  bit     m_halted;
  int     m_drain;
  longint m_stall, m_flush;
  bit     u_frz, u_hz, u_run;
  localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

  function automatic bit uses(input logic [4:0] r);
    return (r != 0) && ((r == ID_rs1 && ID_use_rs1) || (r == ID_rs2 && ID_use_rs2));
  endfunction

  function automatic bit model_hazard();
    return ID_valid && ((IDEX_MemRead && uses(IDEX_rd)) ||
                        (ID_is_branch && IDEX_RegWrite && uses(IDEX_rd)) ||
                        (ID_is_branch && EXMEM_MemRead && uses(EXMEM_rd)));
  endfunction

  // {PC_write, IFID_write, IFID_flush, IDEX_flush, pipe_freeze}
  function automatic logic [4:0] model_ctl();
    if (!rst_n)                       return 5'b00110;
    if (ICache_stall || DCache_stall) return 5'b00001;
    if (m_halted || m_drain > 0)      return 5'b00010;
    if (model_hazard())               return 5'b00010;
    if (ID_valid && ID_halt)          return 5'b01100;
    if (ID_valid && ID_taken)         return 5'b11100;
    return 5'b11000;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_halted = 0; m_drain = 0; m_stall = 0; m_flush = 0;
    end else begin
      u_frz = ICache_stall || DCache_stall;
      u_hz  = model_hazard();
      u_run = !m_halted && m_drain == 0;
      if (u_run && (u_frz || u_hz) && m_stall < CNT_MAX) m_stall++;
      if (u_run && !u_frz && !u_hz && ID_valid && !ID_halt && ID_taken && m_flush < CNT_MAX) m_flush++;
      if (!u_frz) begin
        if (m_drain > 0) begin
          m_drain--;
          if (m_drain == 0) m_halted = 1;
        end else if (u_run && !u_hz && ID_valid && ID_halt) begin
          m_drain = DRAIN_CYCLES;
        end
      end
    end
  end

  // Literal expectations requested by the stimulus process for the current cycle.
  bit         lit_en, lit_cnt_en;
  logic [5:0] lit_exp;
  logic [31:0] lit_cnt_exp;
  string      lit_name;
  int         pass_cnt = 0, chk_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  always @(negedge clk) begin
    logic [5:0]  act6;
    logic [31:0] es, ef;
    act6 = {PC_write, IFID_write, IFID_flush, IDEX_flush, pipe_freeze, halted};
`ifdef HAZARD_PERF_CNT_EN
    es = m_stall[31:0]; ef = m_flush[31:0];
`else
    es = 0; ef = 0;
`endif
    check("ctl_model", {26'd0, act6}, {26'd0, model_ctl(), m_halted});
    check("stall_cycles", stall_cycles, es);
    check("flush_count", flush_count, ef);
    if (lit_en)     check(lit_name, {26'd0, act6}, {26'd0, lit_exp});
    if (lit_cnt_en) check("flush_count_lit", flush_count, lit_cnt_exp);
  end

  task automatic idle();
    ID_valid = 1; ID_rs1 = 0; ID_rs2 = 0; ID_use_rs1 = 0; ID_use_rs2 = 0;
    ID_is_branch = 0; ID_taken = 0; ID_halt = 0; IDEX_MemRead = 0; IDEX_RegWrite = 0;
    IDEX_rd = 0; EXMEM_MemRead = 0; EXMEM_rd = 0; ICache_stall = 0; DCache_stall = 0;
  endtask

  task automatic expect_lit(input string name, input logic [5:0] v);
    lit_name = name; lit_exp = v; lit_en = 1;
  endtask

  task automatic next();
    @(posedge clk); #1;
    lit_en = 0; lit_cnt_en = 0;
  endtask

  int halted_run;

  initial begin
    lit_en = 0; lit_cnt_en = 0; lit_exp = 0; lit_cnt_exp = 0; lit_name = "";
    rst_n = 0; idle();
    expect_lit("reset_outputs", 6'b001100);
    next();
    #1 rst_n = 1;
    expect_lit("first_run", 6'b110000);
    next();

    // rd = x0 never creates a hazard
    IDEX_MemRead = 1; IDEX_rd = 0; ID_rs1 = 0; ID_use_rs1 = 1;
    expect_lit("x0_no_stall", 6'b110000);
    next(); idle();

    // taken branch under D-cache miss: freeze wins, flush deferred
    ID_is_branch = 1; ID_taken = 1; DCache_stall = 1;
    for (int i = 0; i < 4; i++) begin
      expect_lit("freeze_over_taken", 6'b000010);
      next();
    end
    DCache_stall = 0;
    expect_lit("taken_after_freeze", 6'b111000);
    next(); idle();
`ifdef HAZARD_PERF_CNT_EN
    lit_cnt_exp = 1;
`else
    lit_cnt_exp = 0;
`endif
    lit_cnt_en = 1;
    expect_lit("normal_after_taken", 6'b110000);
    next();

    // load-use: one stall cycle
    IDEX_MemRead = 1; IDEX_RegWrite = 1; IDEX_rd = 5; ID_rs1 = 5; ID_use_rs1 = 1;
    expect_lit("load_use_stall", 6'b000100);
    next();
    IDEX_MemRead = 0; IDEX_RegWrite = 0; IDEX_rd = 0; EXMEM_MemRead = 1; EXMEM_rd = 5;
    expect_lit("load_use_release", 6'b110000);
    next(); idle();

    // load feeding a branch: two stall cycles then the redirect
    ID_is_branch = 1; ID_rs1 = 6; ID_use_rs1 = 1; ID_use_rs2 = 1;
    IDEX_MemRead = 1; IDEX_RegWrite = 1; IDEX_rd = 6;
    expect_lit("ld_br_stall1", 6'b000100);
    next();
    IDEX_MemRead = 0; IDEX_RegWrite = 0; IDEX_rd = 0; EXMEM_MemRead = 1; EXMEM_rd = 6;
    expect_lit("ld_br_stall2", 6'b000100);
    next();
    EXMEM_MemRead = 0; EXMEM_rd = 0; ID_taken = 1;
    expect_lit("ld_br_taken", 6'b111000);
    next(); idle();

    // halt drain with a 2-cycle I-cache miss inside; halt+taken means no redirect
    ID_halt = 1; ID_taken = 1;
    expect_lit("halt_in_id", 6'b011000);
    next(); idle();
    expect_lit("drain1", 6'b000100);
    next();
    ICache_stall = 1;
    expect_lit("drain_freeze1", 6'b000010);
    next();
    expect_lit("drain_freeze2", 6'b000010);
    next();
    ICache_stall = 0;
    expect_lit("drain2", 6'b000100);
    next();
    expect_lit("drain3", 6'b000100);
    next();
    ID_halt = 1; ID_taken = 1;
    expect_lit("halted_rise", 6'b000101);
    next();
    ID_halt = 0; ID_taken = 0; ID_is_branch = 1; ID_use_rs1 = 1; ID_rs1 = 3;
    IDEX_RegWrite = 1; IDEX_rd = 3;
    expect_lit("halted_sticky", 6'b000101);
    next(); idle();

    // async reset out of HALTED, then out of mid-DRAIN
    #2 rst_n = 0;
    expect_lit("reset_from_halted", 6'b001100);
    next();
    #1 rst_n = 1;
    ID_halt = 1;
    expect_lit("halt_again", 6'b011000);
    next(); idle();
    #2 rst_n = 0;
    expect_lit("reset_mid_drain", 6'b001100);
    next();
    #1 rst_n = 1;
    expect_lit("clean_after_reset", 6'b110000);
    next();

    // randomized traffic, model-checked every cycle
    halted_run = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!rst_n) rst_n = 1;
      else if (halted_run > 6 || $urandom_range(0, 299) == 0) begin
        rst_n = 0; halted_run = 0;
      end
      ID_valid      = ($urandom_range(0, 7) != 0);
      ID_rs1        = 5'($urandom_range(0, 3));
      ID_rs2        = 5'($urandom_range(0, 3));
      ID_use_rs1    = 1'($urandom_range(0, 1));
      ID_use_rs2    = 1'($urandom_range(0, 1));
      ID_is_branch  = ($urandom_range(0, 3) == 0);
      ID_taken      = ($urandom_range(0, 3) == 0);
      ID_halt       = ($urandom_range(0, 39) == 0);
      IDEX_MemRead  = ($urandom_range(0, 2) == 0);
      IDEX_RegWrite = 1'($urandom_range(0, 1));
      IDEX_rd       = 5'($urandom_range(0, 3));
      EXMEM_MemRead = ($urandom_range(0, 2) == 0);
      EXMEM_rd      = 5'($urandom_range(0, 3));
      ICache_stall  = ($urandom_range(0, 9) == 0);
      DCache_stall  = ($urandom_range(0, 9) == 0);
      next();
      if (m_halted) halted_run++;
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
